// File: rtl/nor_gate.sv
// nor_gate: two-input NOR with registered copy, edge pulses and saturating statistics.
//
// Parameters:
//   CNT_W      - width of the statistics counters (legal range 2..32)
// Ports:
//   clk        - single clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   a, b       - NOR operands
//   y          - combinational ~(a | b); independent of clk and rst
//   y_q        - y registered by one cycle
//   y_rise     - one-cycle pulse after a sampled 0->1 change of y
//   y_fall     - one-cycle pulse after a sampled 1->0 change of y
//   high_cnt   - saturating count of sampled cycles with y = 1
//   toggle_cnt - saturating count of sampled y transitions
module nor_gate #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  output logic             y,
  output logic             y_q,
  output logic             y_rise,
  output logic             y_fall,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] toggle_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             y_q_d;
  logic             y_rise_d;
  logic             y_fall_d;
  logic [CNT_W-1:0] high_cnt_d;
  logic [CNT_W-1:0] toggle_cnt_d;
  logic             y_changed;

  // Pure combinational path; never touched by clk or rst.
  assign y = ~(a | b);

  // Only the value present at the edge matters, so glitches between edges are invisible here.
  assign y_changed = y ^ y_q;

  always_comb begin
    y_q_d        = y;
    y_rise_d     = y & ~y_q;
    y_fall_d     = ~y & y_q;
    high_cnt_d   = high_cnt;
    toggle_cnt_d = toggle_cnt;

    // Counters stick at all-ones instead of wrapping.
    if (y && (high_cnt != CntMax)) begin
      high_cnt_d = high_cnt + CntOne;
    end
    if (y_changed && (toggle_cnt != CntMax)) begin
      toggle_cnt_d = toggle_cnt + CntOne;
    end
  end

  // Reset wins over every load and increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q        <= 1'b0;
      y_rise     <= 1'b0;
      y_fall     <= 1'b0;
      high_cnt   <= '0;
      toggle_cnt <= '0;
    end else begin
      y_q        <= y_q_d;
      y_rise     <= y_rise_d;
      y_fall     <= y_fall_d;
      high_cnt   <= high_cnt_d;
      toggle_cnt <= toggle_cnt_d;
    end
  end

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench for nor_gate: directed scenarios plus random stimulus,
// checked against a cycle-level model of the NOR statistics behaviour.
// Two instances are used: default width and CNT_W=2 for saturation.
module tb_nor_gate;

  logic clk = 1'b0;
  bit   clk_en = 1'b0;
  logic rst;
  logic a, b;

  logic        y0, y1;
  logic        yq0, yq1, rise0, rise1, fall0, fall1;
  logic [15:0] high0, tog0;
  logic [1:0]  high1, tog1;

  int n_vec = 0;
  int n_bad = 0;

  // Reference state shared by both widths, counters kept per instance.
  int m_yq, m_rise, m_fall;
  int m_high [2];
  int m_tog  [2];
  int m_max  [2] = '{65535, 3};

  always #5 if (clk_en) clk = ~clk;

  nor_gate #(.CNT_W(16)) u_dut_w16 (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .y          (y0),
    .y_q        (yq0),
    .y_rise     (rise0),
    .y_fall     (fall0),
    .high_cnt   (high0),
    .toggle_cnt (tog0)
  );

  nor_gate #(.CNT_W(2)) u_dut_w2 (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .y          (y1),
    .y_q        (yq1),
    .y_rise     (rise1),
    .y_fall     (fall1),
    .high_cnt   (high1),
    .toggle_cnt (tog1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_y();
    return (a == 1'b0 && b == 1'b0) ? 1 : 0;
  endfunction

  task automatic model_edge();
    int ys;
    ys = exp_y();
    if (rst) begin
      m_yq = 0; m_rise = 0; m_fall = 0;
      for (int k = 0; k < 2; k++) begin
        m_high[k] = 0;
        m_tog[k]  = 0;
      end
    end else begin
      m_rise = (ys == 1 && m_yq == 0) ? 1 : 0;
      m_fall = (ys == 0 && m_yq == 1) ? 1 : 0;
      for (int k = 0; k < 2; k++) begin
        if (ys == 1 && m_high[k] < m_max[k]) m_high[k] = m_high[k] + 1;
        if (ys != m_yq && m_tog[k] < m_max[k]) m_tog[k] = m_tog[k] + 1;
      end
      m_yq = ys;
    end
  endtask

  task automatic check_all();
    check("y_w16", 32'(y0), 32'(exp_y()));
    check("y_w2", 32'(y1), 32'(exp_y()));
    check("y_q_w16", 32'(yq0), 32'(m_yq));
    check("y_q_w2", 32'(yq1), 32'(m_yq));
    check("rise_w16", 32'(rise0), 32'(m_rise));
    check("rise_w2", 32'(rise1), 32'(m_rise));
    check("fall_w16", 32'(fall0), 32'(m_fall));
    check("fall_w2", 32'(fall1), 32'(m_fall));
    check("high_w16", 32'(high0), 32'(m_high[0]));
    check("high_w2", 32'(high1), 32'(m_high[1]));
    check("tog_w16", 32'(tog0), 32'(m_tog[0]));
    check("tog_w2", 32'(tog1), 32'(m_tog[1]));
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit after the rising edge.
  task automatic step(input logic na, input logic nb, input logic nr);
    @(negedge clk);
    a = na; b = nb; rst = nr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] ab;
    // Combinational truth table with no clock running.
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      a = ab[1]; b = ab[0];
      #1;
      check("comb_y", 32'(y0), 32'((i == 0) ? 1 : 0));
      check("comb_y_w2", 32'(y1), 32'((i == 0) ? 1 : 0));
      #9;
    end

    rst = 1'b1; a = 1'b0; b = 1'b0;
    clk_en = 1'b1;
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("reset_y_held", 32'(y0), 32'd1);

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (i == 0) check("first_rise", 32'(rise0), 32'd1);
    end
    check("high_after5", 32'(high0), 32'd5);
    check("tog_after5", 32'(tog0), 32'd1);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 0) check("first_fall", 32'(fall0), 32'd1);
    end
    check("high_held5", 32'(high0), 32'd5);
    check("tog_after_fall", 32'(tog0), 32'd2);
    check("y_q_low", 32'(yq0), 32'd0);

    // y high for 10 edges: narrow counter must stick at 3.
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0);
    check("sat_w2", 32'(high1), 32'd3);

    // Glitch on b between edges must not be seen.
    @(negedge clk);
    #1 b = 1'b1;
    #1 check("glitch_y", 32'(y0), 32'd0);
    b = 1'b0;
    @(posedge clk);
    model_edge();
    #1 check_all();
    check("glitch_no_fall", 32'(fall0), 32'd0);

    // Mid-run reset with counters nonzero and y=1.
    step(1'b0, 1'b0, 1'b1);
    check("midrst_high", 32'(high0), 32'd0);
    check("midrst_y", 32'(y0), 32'd1);
    step(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(31) == 0));
      check("rise_fall_excl", 32'(rise0 & fall0), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
